booth_seq_controller: RTL

//   Multi-cycle sequencer for radix-2 Booth signed multiplication.

---
 rtl/booth_seq_controller_pkg.sv | 15 +
 rtl/booth_step.sv | 28 ++
 rtl/booth_seq_controller.sv | 87 ++++++++
 3 files changed

// File: rtl/booth_seq_controller_pkg.sv
// rtl/booth_seq_controller_pkg.sv - shared state and Booth pair encodings for the sequential multiplier
package booth_seq_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth recode/add/arith-shift step on the partial product
module booth_step
  import booth_seq_controller_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2*W+1:0] p_in,
  input  logic [W:0]     m,
  output logic [2*W+1:0] p_out
);

  logic [W:0] hi;
  logic [W:0] hi_sum;

  always_comb begin
    hi = p_in[2*W+1:W+1];
    case (p_in[1:0])
      BOOTH_ADD:  hi_sum = hi + m;
      BOOTH_SUB:  hi_sum = hi - m;
      BOOTH_NOP0: hi_sum = hi;
      BOOTH_NOP1: hi_sum = hi;
      default:    hi_sum = hi;
    endcase
    // Sign bit of the W+1-bit hi half is replicated into the vacated top bit.
    p_out = {hi_sum[W], hi_sum, p_in[W:1]};
  end

endmodule

// File: rtl/booth_seq_controller.sv
// rtl/booth_seq_controller.sv - valid/ready sequencer running W Booth steps per signed multiply
module booth_seq_controller
  import booth_seq_controller_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             busy
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [W:0]            m_q, m_d;
  logic [2*W+1:0]        p_q, p_d;
  logic [2*W-1:0]        out_p_q, out_p_d;
  logic [2*W+1:0]        p_step;

  booth_step #(.W(W)) u_step (
    .p_in  (p_q),
    .m     (m_q),
    .p_out (p_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_d     = p_q;
    out_p_d = out_p_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m_d     = {in_a[W-1], in_a};
          p_d     = {{(W+1){1'b0}}, in_x, 1'b0};
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = ST_DONE;
          // Product is captured once here so it survives the return to IDLE.
          out_p_d = p_step[2*W:1];
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      out_p_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_q     <= p_d;
      out_p_q <= out_p_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign out_p     = out_p_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
